// File: rtl/elm_pkg.sv
// Shared constants and reader FSM state type for the layer-2 result export path.
package elm_pkg;
  localparam int DATA_W  = 32;
  localparam int NUM_OUT = 10;
  localparam int ADDR_W  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    DRAIN   = 3'd2,
    PRESENT = 3'd3,
    RESTART = 3'd4
  } reader_state_t;
endpackage

// File: rtl/elm_argmax_tracker.sv
// Running signed argmax over a stream of indexed samples; ties keep the lowest index.
// Macro ELM_TOP2_MARGIN_EN adds a second-best tracker and a saturated best-minus-second margin.
module elm_argmax_tracker
  import elm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [ADDR_W-1:0] index,
  output logic        [ADDR_W-1:0] best_id,
  output logic signed [DATA_W-1:0] best_score
`ifdef ELM_TOP2_MARGIN_EN
  ,
  output logic signed [DATA_W-1:0] second_score,
  output logic signed [DATA_W-1:0] margin
`endif
);

  logic new_best;
  assign new_best = sample_valid && (init || (sample > best_score));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_id    <= '0;
      best_score <= '0;
    end else if (new_best) begin
      best_id    <= index;
      best_score <= sample;
    end
  end

`ifdef ELM_TOP2_MARGIN_EN
  localparam logic signed [DATA_W-1:0] SCORE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic               second_valid;
  logic signed [DATA_W:0] diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      second_score <= '0;
      second_valid <= 1'b0;
    end else if (sample_valid) begin
      if (init) begin
        second_valid <= 1'b0;
      end else if (sample > best_score) begin
        second_score <= best_score;
        second_valid <= 1'b1;
      end else if (!second_valid || (sample > second_score)) begin
        second_score <= sample;
        second_valid <= 1'b1;
      end
    end
  end

  // One extra bit so the subtraction cannot wrap before saturation.
  assign diff = {best_score[DATA_W-1], best_score} - {second_score[DATA_W-1], second_score};

  always_comb begin
    margin = diff[DATA_W-1:0];
    if (diff[DATA_W:DATA_W-1] == 2'b01) margin = SCORE_MAX;
    else if (diff[DATA_W:DATA_W-1] == 2'b10) margin = SCORE_MIN;
  end
`endif

endmodule

// File: rtl/elm_result_reader.sv
// Reads all layer-2 sums out of M3, presents the argmax class on a valid/ready port,
// then pulses start back to the layer-2 controller. Optional macro: ELM_TOP2_MARGIN_EN.
module elm_result_reader
  import elm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     results_ready,
  output logic                     rd_en,
  output logic        [ADDR_W-1:0] rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     class_valid,
  input  logic                     class_ready,
  output logic        [ADDR_W-1:0] class_id,
  output logic signed [DATA_W-1:0] class_score,
  output logic signed [DATA_W-1:0] class_margin,
  output logic                     start_out,
  output logic                     busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_OUT - 1);

  // Handshake: a class transfer happens on any rising edge where class_valid and
  // class_ready are both high; class_valid never drops and the payload never
  // changes until that transfer has happened.

  reader_state_t     state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              cap_valid;
  logic [ADDR_W-1:0] cap_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (results_ready) begin
          state_next = READ;
          cnt_next   = '0;
        end
      end
      READ: begin
        if (cnt == LAST_ADDR) state_next = DRAIN;
        else                  cnt_next   = cnt + ADDR_W'(1);
      end
      DRAIN:   state_next = PRESENT;
      PRESENT: if (class_ready) state_next = RESTART;
      RESTART: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rd_en       = (state == READ);
  assign rd_addr     = rd_en ? cnt : '0;
  assign class_valid = (state == PRESENT);
  assign start_out   = (state == RESTART);
  assign busy        = (state != IDLE);

  // M3 has one cycle of read latency; tag each returning word with its address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_addr  <= '0;
    end else begin
      cap_valid <= rd_en;
      cap_addr  <= rd_addr;
    end
  end

`ifdef ELM_TOP2_MARGIN_EN
  logic signed [DATA_W-1:0] second_score;
`endif

  elm_argmax_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .init         (cap_valid && (cap_addr == '0)),
    .sample_valid (cap_valid),
    .sample       (rd_data),
    .index        (cap_addr),
    .best_id      (class_id),
    .best_score   (class_score)
`ifdef ELM_TOP2_MARGIN_EN
    ,
    .second_score (second_score),
    .margin       (class_margin)
`endif
  );

`ifndef ELM_TOP2_MARGIN_EN
  assign class_margin = '0;
`endif

endmodule

// File: tb/tb_elm_result_reader.sv
// Directed bench for elm_result_reader: M3 model, read-address scoreboard, argmax and handshake checks.
`timescale 1ns/1ps
module tb_elm_result_reader;
  import elm_pkg::*;

  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     results_ready;
  logic                     rd_en;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     class_valid;
  logic                     class_ready;
  logic        [ADDR_W-1:0] class_id;
  logic signed [DATA_W-1:0] class_score;
  logic signed [DATA_W-1:0] class_margin;
  logic                     start_out;
  logic                     busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0;

  logic signed [DATA_W-1:0] mem [NUM_OUT];
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] exp_q[$];

  elm_result_reader dut (
    .clk           (clk),
    .rst           (rst),
    .results_ready (results_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .class_valid   (class_valid),
    .class_ready   (class_ready),
    .class_id      (class_id),
    .class_score   (class_score),
    .class_margin  (class_margin),
    .start_out     (start_out),
    .busy          (busy)
  );

  // Clock and M3 model (one-cycle read latency)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start_out) start_cnt <= start_cnt + 1;
    if (rd_en) begin
      rd_data <= mem[rd_addr];
      rd_log.push_back(rd_addr);
    end
  end

  function automatic logic signed [DATA_W-1:0] exp_margin(input logic signed [DATA_W-1:0] m);
`ifdef ELM_TOP2_MARGIN_EN
    return m;
`else
    return '0;
`endif
  endfunction

  // One full sample: launch, check latency, result, read order, optional backpressure, restart pulse.
  task automatic do_sample(input string name, input logic [ADDR_W-1:0] e_id,
                           input logic signed [DATA_W-1:0] e_score,
                           input logic signed [DATA_W-1:0] e_margin,
                           input int hold, input bit toggle_rr);
    int k;
    int t;
    int s0;
    logic [ADDR_W-1:0] got;
    logic [ADDR_W-1:0] want;
    rd_log.delete();
    exp_q.delete();
    for (int i = 0; i < NUM_OUT; i++) exp_q.push_back(ADDR_W'(i));
    class_ready = (hold == 0);
    @(negedge clk);
    results_ready = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    s0 = start_cnt;
    results_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s first_read: rd_en=%0b rd_addr=%0d busy=%0b, required 1/0/1", name, rd_en, rd_addr, busy);
    end
    t = 0;
    while (class_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (class_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid_timeout: class_valid=%0b after %0d cycles, required 1", name, class_valid, t);
      class_ready = 1'b1;
      return;
    end
    checks++;
    if (cyc - k != NUM_OUT + 1) begin
      errors++;
      $display("FAIL %s latency: valid %0d edges after launch, required %0d", name, cyc - k, NUM_OUT + 1);
    end
    checks++;
    if (class_id !== e_id) begin
      errors++;
      $display("FAIL %s class_id: got %0d, required %0d", name, class_id, e_id);
    end
    checks++;
    if (class_score !== e_score) begin
      errors++;
      $display("FAIL %s class_score: got %0d, required %0d", name, class_score, e_score);
    end
    checks++;
    if (class_margin !== exp_margin(e_margin)) begin
      errors++;
      $display("FAIL %s class_margin: got %0d, required %0d", name, class_margin, exp_margin(e_margin));
    end
    checks++;
    if (rd_log.size() != NUM_OUT) begin
      errors++;
      $display("FAIL %s read_count: got %0d reads, required %0d", name, rd_log.size(), NUM_OUT);
    end
    while (exp_q.size() > 0 && rd_log.size() > 0) begin
      want = exp_q.pop_front();
      got  = rd_log.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s read_addr: got %0d, required %0d", name, got, want);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (toggle_rr) results_ready = ~results_ready;
      checks++;
      if (class_valid !== 1'b1 || class_id !== e_id || class_score !== e_score ||
          start_out !== 1'b0 || rd_en !== 1'b0 || rd_log.size() != 0) begin
        errors++;
        $display("FAIL %s hold[%0d]: valid=%0b id=%0d score=%0d start=%0b rd_en=%0b reads=%0d, required 1/%0d/%0d/0/0/0",
                 name, h, class_valid, class_id, class_score, start_out, rd_en, rd_log.size(), e_id, e_score);
      end
    end
    results_ready = 1'b0;
    class_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (start_out !== 1'b1 || class_valid !== 1'b0 || class_id !== e_id || class_score !== e_score) begin
      errors++;
      $display("FAIL %s restart: start=%0b valid=%0b id=%0d score=%0d, required 1/0/%0d/%0d",
               name, start_out, class_valid, class_id, class_score, e_id, e_score);
    end
    @(negedge clk);
    checks++;
    if (start_out !== 1'b0 || busy !== 1'b0 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL %s idle_after: start=%0b busy=%0b pulses=%0d, required 0/0/1", name, start_out, busy, start_cnt - s0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    results_ready = 1'b0;
    class_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_en !== 1'b0 || rd_addr !== '0 || class_valid !== 1'b0 || start_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rd_en=%0b rd_addr=%0d valid=%0b start=%0b busy=%0b, required all 0",
               rd_en, rd_addr, class_valid, start_out, busy);
    end
    checks++;
    if (class_id !== '0 || class_score !== '0 || class_margin !== '0) begin
      errors++;
      $display("FAIL reset_data: id=%0d score=%0d margin=%0d, required 0/0/0", class_id, class_score, class_margin);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    mem = '{32'sd5, -32'sd3, 32'sd17, 32'sd2, 32'sd0, 32'sd9, -32'sd100, 32'sd16, 32'sd1, 32'sd4};
    do_sample("basic", 4'd2, 32'sd17, 32'sd1, 0, 1'b0);
  endtask

  task automatic test_all_equal();
    for (int i = 0; i < NUM_OUT; i++) mem[i] = -32'sd7;
    do_sample("all_equal", 4'd0, -32'sd7, 32'sd0, 0, 1'b0);
  endtask

  task automatic test_extreme_neg();
    for (int i = 0; i < NUM_OUT; i++) mem[i] = S_MIN;
    mem[NUM_OUT-1] = -32'sd1;
    do_sample("extreme_neg", 4'd9, -32'sd1, S_MAX, 0, 1'b0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < NUM_OUT; i++) mem[i] = S_MIN;
    mem[0] = S_MAX;
    do_sample("saturate", 4'd0, S_MAX, S_MAX, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    mem = '{32'sd5, -32'sd3, 32'sd17, 32'sd2, 32'sd0, 32'sd9, -32'sd100, 32'sd16, 32'sd1, 32'sd4};
    do_sample("backpressure", 4'd2, 32'sd17, 32'sd1, 20, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t;
    int s0;
    mem = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8, 32'sd99, 32'sd10};
    s0 = start_cnt;
    @(negedge clk);
    results_ready = 1'b1;
    @(posedge clk);
    #1;
    results_ready = 1'b0;
    @(negedge clk);
    t = 0;
    while (rd_addr !== 4'd4 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (rd_addr !== 4'd4 || rd_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reach: rd_addr=%0d rd_en=%0b, required 4/1", rd_addr, rd_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rd_en !== 1'b0 || busy !== 1'b0 || class_valid !== 1'b0 || start_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drop: rd_en=%0b busy=%0b valid=%0b start=%0b, required all 0",
               rd_en, busy, class_valid, start_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (start_cnt != s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nostart: pulses=%0d busy=%0b, required 0/0", start_cnt - s0, busy);
    end
    do_sample("reset_mid_rerun", 4'd8, 32'sd99, 32'sd89, 0, 1'b0);
  endtask

  task automatic test_tie();
    for (int i = 0; i < NUM_OUT; i++) mem[i] = i;
    mem[3] = 32'sd50;
    mem[7] = 32'sd50;
    do_sample("tie", 4'd3, 32'sd50, 32'sd0, 6, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_equal();
    test_extreme_neg();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_tie();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
